// File: rtl/window_sum_calc.sv
// window_sum_calc
//   Pipelined signed adder tree. It reduces the N_TERMS packed line sums of one
//   detection window to a single window sum. Each tree level is registered, so
//   the latency is log2(N_TERMS) cycles, and the block accepts one window per
//   cycle.
//
//   Ports
//     clk        : system clock, rising edge
//     rst_n      : asynchronous active-low reset
//     in_valid   : windowdata is valid this cycle
//     windowdata : N_TERMS signed DATA_W-bit terms; term i at [DATA_W*i +: DATA_W]
//     out_valid  : windowsum is valid this cycle
//     windowsum  : signed sum, either wrapped or saturated to DATA_W bits
module window_sum_calc #(
  parameter int unsigned N_TERMS  = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SATURATE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [N_TERMS*DATA_W-1:0]   windowdata,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           windowsum
);

  localparam int unsigned L  = $clog2(N_TERMS);
  localparam int unsigned LW = DATA_W + L;

  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Tree nodes use heap numbering. Node 1 is the root, the children of node n
  // are 2n and 2n+1, and nodes N_TERMS..2*N_TERMS-1 are the input terms.
  // Every node is presented sign-extended to the full width. Each registered
  // node stores only DATA_W+level bits, because that width always holds its
  // exact value.
  logic signed [LW-1:0] w_node [1:2*N_TERMS-1];

  genvar n;
  for (n = 1; n < 2*N_TERMS; n++) begin : g_node
    if (n >= N_TERMS) begin : g_leaf
      assign w_node[n] = LW'($signed(windowdata[DATA_W*(n-N_TERMS) +: DATA_W]));
    end else begin : g_add
      localparam int unsigned LEV = L + 1 - $clog2(n + 1);
      localparam int unsigned W   = DATA_W + LEV;

      logic signed [W-1:0] r_sum;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sum <= '0;
        end else begin
          r_sum <= W'(w_node[2*n] + w_node[2*n+1]);
        end
      end

      assign w_node[n] = LW'(r_sum);
    end
  end

  // Valid shift register. It travels alongside the data levels.
  logic [L-1:0] r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld <= L'({r_vld, in_valid});
    end
  end

  assign out_valid = r_vld[L-1];

  logic signed [LW-1:0] w_full;
  assign w_full = w_node[1];

  // Output reduction is combinational on the root register, so it adds no
  // latency.
  always_comb begin
    windowsum = w_full[DATA_W-1:0];
    if (SATURATE != 0) begin
      if (w_full > LW'(SMAX)) begin
        windowsum = SMAX;
      end else if (w_full < LW'(SMIN)) begin
        windowsum = SMIN;
      end
    end
  end

endmodule

// File: tb/tb_window_sum_calc.sv
module tb_window_sum_calc;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [255:0] windowdata;
  logic         out_valid_w, out_valid_s;
  logic [31:0]  windowsum_w, windowsum_s;

  int unsigned n_vec;
  int unsigned n_err;

  window_sum_calc #(.N_TERMS(8), .DATA_W(32), .SATURATE(0)) u_dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .windowdata (windowdata),
    .out_valid  (out_valid_w),
    .windowsum  (windowsum_w)
  );

  window_sum_calc #(.N_TERMS(8), .DATA_W(32), .SATURATE(1)) u_dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .windowdata (windowdata),
    .out_valid  (out_valid_s),
    .windowsum  (windowsum_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Puts one valid window in, then steps to the cycle in which its result is due.
  task automatic one_window(input logic [255:0] w);
    windowdata = w;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    windowdata = '0;
    step();
    step();
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    windowdata = '0;

    #3;
    chk("rst_valid_w", {31'd0, out_valid_w}, 32'd0);
    chk("rst_sum_w",   windowsum_w,          32'd0);
    chk("rst_valid_s", {31'd0, out_valid_s}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic sum: eight terms of 10
    one_window({8{32'd10}});
    chk("basic_valid", {31'd0, out_valid_w}, 32'd1);
    chk("basic_sum",   windowsum_w,          32'd80);
    chk("basic_sat",   windowsum_s,          32'd80);
    step();
    chk("basic_after", {31'd0, out_valid_w}, 32'd0);

    // Signed mix: terms {-5,3,-100,7,0,1,-1,20}, sum -75
    one_window({32'sd20, -32'sd1, 32'sd1, 32'sd0, 32'sd7, -32'sd100, 32'sd3, -32'sd5});
    chk("mix_valid", {31'd0, out_valid_w}, 32'd1);
    chk("mix_sum_w", windowsum_w,          32'hFFFF_FFB5);
    chk("mix_sum_s", windowsum_s,          32'hFFFF_FFB5);
    step();

    // Back-to-back windows A, B, C, a gap, then D
    in_valid   = 1'b1;
    windowdata = {8{32'd1}};
    step();
    windowdata = {8{32'hFFFF_FFFE}};
    step();
    windowdata = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    step();
    chk("pipeA_valid", {31'd0, out_valid_w}, 32'd1);
    chk("pipeA_sum",   windowsum_w,          32'd8);
    in_valid   = 1'b0;
    windowdata = {8{32'd99}};
    step();
    chk("pipeB_valid", {31'd0, out_valid_w}, 32'd1);
    chk("pipeB_sum",   windowsum_w,          32'hFFFF_FFF0);
    in_valid   = 1'b1;
    windowdata = {8{32'd3}};
    step();
    in_valid   = 1'b0;
    chk("pipeC_valid", {31'd0, out_valid_w}, 32'd1);
    chk("pipeC_sum",   windowsum_w,          32'd28);
    step();
    chk("gap_valid",   {31'd0, out_valid_w}, 32'd0);
    step();
    chk("pipeD_valid", {31'd0, out_valid_w}, 32'd1);
    chk("pipeD_sum",   windowsum_w,          32'd24);
    step();
    chk("pipe_end",    {31'd0, out_valid_w}, 32'd0);

    // Positive overflow: 8 * 0x7FFFFFFF = 0x3_FFFFFFF8
    one_window({8{32'h7FFF_FFFF}});
    chk("ovp_wrap", windowsum_w,          32'hFFFF_FFF8);
    chk("ovp_sat",  windowsum_s,          32'h7FFF_FFFF);
    chk("ovp_vs",   {31'd0, out_valid_s}, 32'd1);
    step();

    // Negative overflow: 8 * -2^31 = -2^34
    one_window({8{32'h8000_0000}});
    chk("ovn_wrap", windowsum_w, 32'h0000_0000);
    chk("ovn_sat",  windowsum_s, 32'h8000_0000);
    step();

    // Asynchronous reset while a valid result is being presented
    one_window({8{32'd10}});
    chk("pre_rst_valid", {31'd0, out_valid_w}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_w", {31'd0, out_valid_w}, 32'd0);
    chk("arst_sum_w",   windowsum_w,          32'd0);
    chk("arst_valid_s", {31'd0, out_valid_s}, 32'd0);
    chk("arst_sum_s",   windowsum_s,          32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset in flight: the window must never emerge
    windowdata = {8{32'd5}};
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("flight_novalid", {31'd0, out_valid_w}, 32'd0);
      step();
    end

    // The pipe works again after the reset
    one_window({8{32'd2}});
    chk("post_valid", {31'd0, out_valid_w}, 32'd1);
    chk("post_sum",   windowsum_w,          32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
